hps_sprite_cmd_sequencer: RTL and testbench
===========================================

Name: hps_sprite_cmd_sequencer

Overview:
Collects byte-wide HPS register writes (address 0-6) into 7-byte sprite commands and queues them in a small FIFO. Drains the FIFO into the sprite attribute table only while the VGA side reports vertical blank, so the table never changes mid-frame. Sits between the HPS Avalon slave port and the sprite table inside fpga_top_level.

Parameters:
FIFO_DEPTH, 4, command slots; power of two, 2..16
SPRITE_BITS, 5, table index width; sprite index = reg0[SPRITE_BITS-1:0]

Ports:
clk50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
hps_chipselect  in  1  Avalon slave select
hps_write  in  1  write strobe, qualified by chipselect
hps_read  in  1  read strobe, qualified by chipselect
hps_address  in  3  register address
hps_writedata  in  8  write data
hps_readdata  out  8  status read data, registered
vblank  in  1  level, high during vertical blank (sync domain = clk50)
tbl_we  out  1  sprite table write enable, one-cycle pulse per entry
tbl_addr  out  SPRITE_BITS  sprite table index
tbl_data  out  48  {flags, y, x, b, g, r}
overflow  out  1  sticky: a commit was dropped while FIFO full

Behaviour:
- Reset (reset=0, async): all shadow regs 0, FIFO empty, count 0, FSM IDLE, tbl_we=0, tbl_addr=0, tbl_data=0, hps_readdata=0, overflow=0.
- Write = chipselect & write, sampled on posedge clk50.
- Addresses 0-5 load shadow regs: 0 = index, 1 = r, 2 = g, 3 = b, 4 = x, 5 = y.
- Shadow regs hold their values after a commit; they are not cleared.
- Address 6 = flags + commit. The pushed entry is {writedata, shadow5..shadow0}, so flags come from the same-cycle writedata.
  - FIFO not full: push, count+1.
  - FIFO full and no pop this cycle: drop the entry, set overflow.
- Address 7 write:
  - bit0=1 flushes the FIFO (count 0, pointers 0).
  - bit1=1 clears overflow.
  - Both bits may be set in one write.
- Address 7 read: hps_readdata next cycle = {3'b0, overflow, count[3:0]}, with count zero-extended. Reads of 0-6 return 0.
- FSM states IDLE, WAIT_BLANK, WRITE:
  - IDLE: FIFO non-empty -> WAIT_BLANK.
  - WAIT_BLANK: vblank=1 and non-empty -> WRITE. Empty (flushed) -> IDLE.
  - WRITE: tbl_we=1 for exactly this cycle, and the head is popped this cycle. Next state: WAIT_BLANK if non-empty after the pop, else IDLE.
- Latency: a commit at edge N with FIFO empty and vblank=1 gives tbl_we high in the cycle after edge N+2, i.e. 2 cycles from commit to table write.
- Back-to-back: with a full FIFO and vblank held, entries drain at one every 2 cycles (WAIT_BLANK/WRITE alternation).
- vblank falls during WRITE: the write completes; the next entry waits for the next vblank.
- Simultaneous push and pop with the FIFO full: the push is accepted, count is unchanged, and no overflow is set.
- Flush in the same cycle as a WRITE pop: the write completes and the FIFO ends empty.
- Flush and commit in the same cycle: the flush wins, the FIFO ends empty, and the commit is dropped without setting overflow.
- tbl_addr and tbl_data are registered alongside tbl_we and hold their last value when tbl_we=0.
- Pointer wrap is modulo FIFO_DEPTH. count has width $clog2(FIFO_DEPTH)+1.

Decomposition:
- Package hps_sprite_pkg holds:
  - address constants REG_IDX..REG_CTRL (0..7)
  - typedef sprite_cmd_t (packed struct flags, y, x, b, g, r, idx)
  - typedef seq_state_t {IDLE, WAIT_BLANK, WRITE}
  - CTRL_FLUSH_BIT=0, CTRL_CLROVF_BIT=1
- One sub-module, cmd_fifo: synchronous FIFO, parameter depth, push/pop/flush/full/empty/count, with push-when-full-with-pop permitted.

Test Plan:
- Reset mid-drain: assert reset while in WRITE -> tbl_we=0 immediately, count=0, overflow=0; after release, no further table writes occur.
- Single command: write 0xFD,0xFF,0xFF,0xFF,0x00,0x00 to addr 0-5, then 0x07 to addr 6, vblank=1 -> exactly one tbl_we pulse 2 cycles after the commit.
  - tbl_addr = 0x1D (SPRITE_BITS=5).
  - tbl_data = 48'h07_00_00_FF_FF_FF.
- Blank gating: vblank=0, commit 3 entries -> no tbl_we and status count=3. Raise vblank -> 3 pulses at 2-cycle spacing, with data in commit order.
- Overflow: vblank=0, commit 5 times (DEPTH 4) -> count=4, overflow=1, and the 5th entry is never written. Write 0x02 to addr 7 -> overflow=0.
- Full push+pop: FIFO full, vblank=1, commit timed to the WRITE cycle -> overflow stays 0 and count stays 4.
- Flush: 3 pending, vblank=0, write 0x01 to addr 7 -> count=0 and FSM back to IDLE. Raising vblank then produces no writes.

Source files
------------

// File: rtl/hps_sprite_pkg.sv
// Shared constants and types for the HPS sprite command sequencer.
// A command is seven bytes: index plus colour, position and flags.
package hps_sprite_pkg;

  localparam logic [2:0] REG_IDX   = 3'd0;
  localparam logic [2:0] REG_R     = 3'd1;
  localparam logic [2:0] REG_G     = 3'd2;
  localparam logic [2:0] REG_B     = 3'd3;
  localparam logic [2:0] REG_X     = 3'd4;
  localparam logic [2:0] REG_Y     = 3'd5;
  localparam logic [2:0] REG_FLAGS = 3'd6;
  localparam logic [2:0] REG_CTRL  = 3'd7;

  localparam int CTRL_FLUSH_BIT  = 0;
  localparam int CTRL_CLROVF_BIT = 1;

  // Packed MSB-first, so bits [55:8] are exactly the 48-bit table word.
  typedef struct packed {
    logic [7:0] flags;
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] idx;
  } sprite_cmd_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BLANK = 2'd1,
    WRITE      = 2'd2
  } seq_state_t;

endpackage

// File: rtl/hps_sprite_cmd_sequencer_cmd_fifo.sv
// Synchronous command FIFO with flush; a push into a full FIFO is taken
// when a pop happens in the same cycle.
module cmd_fifo
  import hps_sprite_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  sprite_cmd_t wdata,
  output sprite_cmd_t rdata,
  output logic        full,
  output logic        empty,
  output logic [CW-1:0] count,
  output logic        next_empty
);

  sprite_cmd_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          push_ok;
  logic          pop_ok;

  // push/full act as valid/ready: an entry transfers when push is high and
  // the FIFO is not full or is popping this cycle; pop is ignored when empty.
  // Flush overrides both and leaves the FIFO empty.
  assign pop_ok     = pop & ~empty;
  assign push_ok    = push & (~full | pop_ok);
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign rdata      = mem[rd_ptr];
  assign count_nxt  = flush ? '0 : (count + CW'(push_ok) - CW'(pop_ok));
  assign next_empty = (count_nxt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/hps_sprite_cmd_sequencer.sv
// Gathers HPS byte writes into sprite commands, queues them, and drains the
// queue into the sprite attribute table only during vertical blank.
module hps_sprite_cmd_sequencer
  import hps_sprite_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SPRITE_BITS = 5
) (
  input  logic                   clk50,
  input  logic                   reset,
  input  logic                   hps_chipselect,
  input  logic                   hps_write,
  input  logic                   hps_read,
  input  logic [2:0]             hps_address,
  input  logic [7:0]             hps_writedata,
  output logic [7:0]             hps_readdata,
  input  logic                   vblank,
  output logic                   tbl_we,
  output logic [SPRITE_BITS-1:0] tbl_addr,
  output logic [47:0]            tbl_data,
  output logic                   overflow,
  output seq_state_t             dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  seq_state_t    state, state_nxt;
  logic [7:0]    shadow [6];
  sprite_cmd_t   push_cmd;
  sprite_cmd_t   head;
  logic          wr_en, rd_en, commit, ctrl_wr, flush, clr_ovf;
  logic          fifo_full, fifo_empty, fifo_next_empty;
  logic [CW-1:0] count;
  logic [3:0]    count4;
  logic          pop, issue;

  assign wr_en   = hps_chipselect & hps_write;
  assign rd_en   = hps_chipselect & hps_read;
  assign commit  = wr_en && (hps_address == REG_FLAGS);
  assign ctrl_wr = wr_en && (hps_address == REG_CTRL);
  assign flush   = ctrl_wr & hps_writedata[CTRL_FLUSH_BIT];
  assign clr_ovf = ctrl_wr & hps_writedata[CTRL_CLROVF_BIT];
  assign count4  = 4'(count);
  assign pop     = (state == WRITE);
  assign dbg_state = state;

  // Flags ride in with the commit write itself, not from a shadow register.
  assign push_cmd = '{flags: hps_writedata, y: shadow[5], x: shadow[4],
                      b: shadow[3], g: shadow[2], r: shadow[1], idx: shadow[0]};

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk50),
    .rst_n      (reset),
    .push       (commit),
    .pop        (pop),
    .flush      (flush),
    .wdata      (push_cmd),
    .rdata      (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (count),
    .next_empty (fifo_next_empty)
  );

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) shadow[i] <= '0;
    end else if (wr_en && (hps_address < REG_FLAGS)) begin
      shadow[hps_address] <= hps_writedata;
    end
  end

  // A flushed commit is simply lost; only a genuine full-FIFO drop is sticky.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end else if (commit && fifo_full && !(pop && !fifo_empty) && !flush) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      hps_readdata <= '0;
    end else if (rd_en) begin
      hps_readdata <= (hps_address == REG_CTRL) ? {3'b000, overflow, count4} : 8'h00;
    end
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:       if (!fifo_empty) state_nxt = WAIT_BLANK;
      WAIT_BLANK: begin
        if (fifo_empty) begin
          state_nxt = IDLE;
        end else if (vblank) begin
          state_nxt = WRITE;
          issue     = 1'b1;
        end
      end
      WRITE:      state_nxt = fifo_next_empty ? IDLE : WAIT_BLANK;
      default:    state_nxt = IDLE;
    endcase
  end

  // Table outputs are loaded on entry to WRITE, so tbl_we is high for
  // exactly the WRITE cycle and the head pops at the end of it.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      tbl_we   <= 1'b0;
      tbl_addr <= '0;
      tbl_data <= '0;
    end else begin
      tbl_we <= issue;
      if (issue) begin
        tbl_addr <= SPRITE_BITS'(head.idx);
        tbl_data <= {head.flags, head.y, head.x, head.b, head.g, head.r};
      end
    end
  end

endmodule

// File: tb/tb_hps_sprite_cmd_sequencer.sv
// Bench for hps_sprite_cmd_sequencer: directed scenarios plus random traffic,
// all checked against a queue-based model of the command path.
module tb_hps_sprite_cmd_sequencer;
  import hps_sprite_pkg::*;

  localparam int DEPTH = 4;
  localparam int SB    = 5;

  logic          clk50 = 1'b0;
  logic          reset = 1'b0;
  logic          hps_chipselect = 1'b0;
  logic          hps_write = 1'b0;
  logic          hps_read = 1'b0;
  logic [2:0]    hps_address = '0;
  logic [7:0]    hps_writedata = '0;
  logic [7:0]    hps_readdata;
  logic          vblank = 1'b0;
  logic          tbl_we;
  logic [SB-1:0] tbl_addr;
  logic [47:0]   tbl_data;
  logic          overflow;
  seq_state_t    dbg_state;

  always #10 clk50 = ~clk50;

  hps_sprite_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .SPRITE_BITS(SB)) dut (
    .clk50          (clk50),
    .reset          (reset),
    .hps_chipselect (hps_chipselect),
    .hps_write      (hps_write),
    .hps_read       (hps_read),
    .hps_address    (hps_address),
    .hps_writedata  (hps_writedata),
    .hps_readdata   (hps_readdata),
    .vblank         (vblank),
    .tbl_we         (tbl_we),
    .tbl_addr       (tbl_addr),
    .tbl_data       (tbl_data),
    .overflow       (overflow),
    .dbg_state      (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: pending commands, sticky drop flag, shadow bytes, and a drain
  // engine that needs one settle cycle after work appears or after a write.
  logic [55:0]   exp_q[$];
  logic          m_ovf = 1'b0;
  logic [7:0]    m_sh [6];
  logic          m_we = 1'b0;
  logic [SB-1:0] m_addr = '0;
  logic [47:0]   m_data = '0;
  logic [7:0]    m_rd = '0;
  logic          m_armed = 1'b0;

  always @(posedge clk50 or negedge reset) begin : model
    bit wr, commit, flush, clr, pop, issue;
    int pre;
    if (!reset) begin
      exp_q.delete();
      m_ovf = 1'b0;
      foreach (m_sh[i]) m_sh[i] = 8'h00;
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_rd = 8'h00;
      m_armed = 1'b0;
    end else begin
      wr     = hps_chipselect && hps_write;
      commit = wr && (hps_address == 3'd6);
      flush  = wr && (hps_address == 3'd7) && hps_writedata[0];
      clr    = wr && (hps_address == 3'd7) && hps_writedata[1];
      pre    = exp_q.size();
      if (hps_chipselect && hps_read)
        m_rd = (hps_address == 3'd7) ? {3'b000, m_ovf, 4'(pre)} : 8'h00;
      issue = m_armed && vblank && (pre > 0);
      pop   = m_we && (pre > 0);
      if (issue) begin
        m_addr = exp_q[0][SB-1:0];
        m_data = exp_q[0][55:8];
      end
      if (pop) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (commit) begin
        if (pre < DEPTH || pop)
          exp_q.push_back({hps_writedata, m_sh[5], m_sh[4], m_sh[3], m_sh[2], m_sh[1], m_sh[0]});
        else
          m_ovf = 1'b1;
      end
      if (clr) m_ovf = 1'b0;
      if (wr && hps_address < 3'd6) m_sh[hps_address] = hps_writedata;
      if (m_we)       m_armed = (exp_q.size() > 0);
      else if (issue) m_armed = 1'b0;
      else            m_armed = (pre > 0);
      m_we = issue;
    end
  end

  always @(negedge clk50) begin : compare
    if (reset) begin
      check("tbl_we", tbl_we, m_we);
      check("tbl_addr", tbl_addr, m_addr);
      check("tbl_data", tbl_data, m_data);
      check("readdata", hps_readdata, m_rd);
      check("overflow", overflow, m_ovf);
    end
  end

  int cyc = 0;
  int we_cnt = 0;
  logic [47:0] seen_data[$];
  int seen_cyc[$];
  always @(posedge clk50) cyc++;
  always @(negedge clk50) begin
    if (reset && tbl_we) begin
      we_cnt++;
      seen_data.push_back(tbl_data);
      seen_cyc.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    hps_chipselect = 1'b1;
    hps_write      = 1'b1;
    hps_address    = a;
    hps_writedata  = d;
    @(negedge clk50);
    hps_chipselect = 1'b0;
    hps_write      = 1'b0;
  endtask

  task automatic rd_status(output logic [7:0] v);
    hps_chipselect = 1'b1;
    hps_read       = 1'b1;
    hps_address    = 3'd7;
    @(negedge clk50);
    hps_chipselect = 1'b0;
    hps_read       = 1'b0;
    v = hps_readdata;
  endtask

  task automatic load(input logic [55:0] c);
    wr(3'd0, c[7:0]);
    wr(3'd1, c[15:8]);
    wr(3'd2, c[23:16]);
    wr(3'd3, c[31:24]);
    wr(3'd4, c[39:32]);
    wr(3'd5, c[47:40]);
    wr(3'd6, c[55:48]);
  endtask

  logic [55:0] ents [5];
  logic [7:0]  st;
  int          w0;

  initial begin
    ents[0] = 56'h01_10_20_30_40_50_03;
    ents[1] = 56'h02_11_21_31_41_51_1F;
    ents[2] = 56'h04_12_22_32_42_52_07;
    ents[3] = 56'h08_13_23_33_43_53_11;
    ents[4] = 56'h80_EE_DD_CC_BB_AA_09;

    idle(3);
    check("rst_we", tbl_we, 1'b0);
    check("rst_addr", tbl_addr, '0);
    check("rst_data", tbl_data, '0);
    check("rst_rdata", hps_readdata, 8'h00);
    check("rst_ovf", overflow, 1'b0);
    reset = 1'b1;
    idle(1);

    // Single command: latency of two cycles from the commit edge.
    vblank = 1'b1;
    w0 = we_cnt;
    load(56'h07_00_00_FF_FF_FF_FD);
    check("lat_c1", tbl_we, 1'b0);
    idle(1);
    check("lat_c2", tbl_we, 1'b0);
    idle(1);
    check("lat_we", tbl_we, 1'b1);
    check("lat_addr", tbl_addr, 5'h1D);
    check("lat_data", tbl_data, 48'h07_00_00_FF_FF_FF);
    idle(4);
    check("single_pulse", we_cnt - w0, 1);

    // Blank gating: entries wait, then drain in order every other cycle.
    vblank = 1'b0;
    w0 = we_cnt;
    for (int i = 0; i < 3; i++) load(ents[i]);
    idle(2);
    rd_status(st);
    check("gate_status", st, 8'h03);
    check("gate_nowe", we_cnt - w0, 0);
    seen_data.delete();
    seen_cyc.delete();
    vblank = 1'b1;
    idle(10);
    check("gate_n", seen_data.size(), 3);
    if (seen_data.size() == 3) begin
      for (int i = 0; i < 3; i++) check("gate_order", seen_data[i], ents[i][55:8]);
      check("gate_gap1", seen_cyc[1] - seen_cyc[0], 2);
      check("gate_gap2", seen_cyc[2] - seen_cyc[1], 2);
    end

    // Overflow: fifth commit dropped, flag sticky until cleared.
    vblank = 1'b0;
    for (int i = 0; i < 5; i++) load(ents[i]);
    rd_status(st);
    check("ovf_status", st, 8'h14);
    wr(3'd7, 8'h02);
    rd_status(st);
    check("ovf_cleared", st, 8'h04);
    seen_data.delete();
    vblank = 1'b1;
    idle(12);
    check("ovf_n", seen_data.size(), 4);
    if (seen_data.size() == 4) check("ovf_last", seen_data[3], ents[3][55:8]);

    // Full FIFO: commit lands on the WRITE cycle, so push and pop coincide.
    vblank = 1'b0;
    for (int i = 0; i < 4; i++) load(ents[i]);
    idle(2);
    vblank = 1'b1;
    idle(1);
    check("fpp_we", tbl_we, 1'b1);
    vblank = 1'b0;
    wr(3'd6, 8'hAA);
    rd_status(st);
    check("fpp_status", st, 8'h04);
    check("fpp_ovf", overflow, 1'b0);

    // Flush: pending entries discarded, engine returns to idle.
    wr(3'd7, 8'h01);
    for (int i = 0; i < 3; i++) load(ents[i]);
    idle(2);
    rd_status(st);
    check("flush_pre", st, 8'h03);
    wr(3'd7, 8'h01);
    idle(1);
    check("flush_idle", 64'(dbg_state), 64'(IDLE));
    rd_status(st);
    check("flush_status", st, 8'h00);
    w0 = we_cnt;
    vblank = 1'b1;
    idle(10);
    check("flush_nowe", we_cnt - w0, 0);

    // Reset while a table write is in flight.
    vblank = 1'b0;
    load(ents[1]);
    load(ents[2]);
    vblank = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tbl_we) break;
      @(negedge clk50);
    end
    check("rmd_saw_we", tbl_we, 1'b1);
    reset = 1'b0;
    #1;
    check("rmd_we", tbl_we, 1'b0);
    check("rmd_ovf", overflow, 1'b0);
    idle(2);
    reset = 1'b1;
    rd_status(st);
    check("rmd_status", st, 8'h00);
    w0 = we_cnt;
    idle(10);
    check("rmd_nowe", we_cnt - w0, 0);

    // Random traffic against the model.
    wr(3'd7, 8'h03);
    for (int n = 0; n < 3000; n++) begin
      int r;
      if ($urandom_range(0, 19) == 0) vblank = ~vblank;
      r = $urandom_range(0, 99);
      if (r < 40) idle(1);
      else if (r < 82) wr(3'($urandom_range(0, 6)), 8'($urandom));
      else if (r < 86) wr(3'd7, 8'($urandom_range(0, 3)));
      else begin
        hps_chipselect = 1'b1;
        hps_read       = 1'b1;
        hps_address    = 3'($urandom_range(0, 7));
        idle(1);
        hps_chipselect = 1'b0;
        hps_read       = 1'b0;
      end
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
